// File: rtl/ex_mem_reg_if.sv
// EX/MEM pipeline register bus: EX results, stall/flush control and the
// multiply-accumulate state carried back to EX.
interface ex_mem_reg_if #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int STALL_W = 6
);
    logic [STALL_W-1:0]  stall;
    logic                flush;
    logic [ADDR_W-1:0]   ex_wd;
    logic                ex_wreg;
    logic [DATA_W-1:0]   ex_wdata;
    logic [DATA_W-1:0]   ex_hi;
    logic [DATA_W-1:0]   ex_lo;
    logic                ex_whilo;
    logic [2*DATA_W-1:0] hilo_i;
    logic [1:0]          cnt_i;

    logic [ADDR_W-1:0]   mem_wd;
    logic                mem_wreg;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem_hi;
    logic [DATA_W-1:0]   mem_lo;
    logic                mem_whilo;
    logic                mem_valid;
    logic [2*DATA_W-1:0] hilo_o;
    logic [1:0]          cnt_o;

    // EX stage / stall controller side
    modport master (
        output stall, flush, ex_wd, ex_wreg, ex_wdata, ex_hi, ex_lo, ex_whilo,
               hilo_i, cnt_i,
        input  mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo,
               mem_valid, hilo_o, cnt_o
    );

    // the pipeline register itself
    modport slave (
        input  stall, flush, ex_wd, ex_wreg, ex_wdata, ex_hi, ex_lo, ex_whilo,
               hilo_i, cnt_i,
        output mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo,
               mem_valid, hilo_o, cnt_o
    );
endinterface

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: advances, bubbles, holds or flushes the MEM slot
// and keeps the madd/msub partial product alive across EX stall cycles.
module ex_mem_reg #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int STALL_W = 6
) (
    input  logic         clk,
    input  logic         rst,
    ex_mem_reg_if.slave  bus
);

    logic [ADDR_W-1:0]   r_mem_wd;
    logic                r_mem_wreg;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [DATA_W-1:0]   r_mem_hi;
    logic [DATA_W-1:0]   r_mem_lo;
    logic                r_mem_whilo;
    logic                r_mem_valid;
    logic [2*DATA_W-1:0] r_hilo;
    logic [1:0]          r_cnt;

    logic                w_ex_stall;
    logic                w_mem_stall;

    assign w_ex_stall  = bus.stall[3];
    assign w_mem_stall = bus.stall[4];

    // Priority: flush, then advance when EX runs (EX running with MEM stalled
    // is never requested, so it simply advances), then bubble-and-capture
    // when only EX stalls, else hold everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem_wd    <= '0;
            r_mem_wreg  <= 1'b0;
            r_mem_wdata <= '0;
            r_mem_hi    <= '0;
            r_mem_lo    <= '0;
            r_mem_whilo <= 1'b0;
            r_mem_valid <= 1'b0;
            r_hilo      <= '0;
            r_cnt       <= '0;
        end else if (bus.flush) begin
            r_mem_wd    <= '0;
            r_mem_wreg  <= 1'b0;
            r_mem_wdata <= '0;
            r_mem_hi    <= '0;
            r_mem_lo    <= '0;
            r_mem_whilo <= 1'b0;
            r_mem_valid <= 1'b0;
            r_hilo      <= '0;
            r_cnt       <= '0;
        end else if (!w_ex_stall) begin
            r_mem_wd    <= bus.ex_wd;
            r_mem_wreg  <= bus.ex_wreg;
            r_mem_wdata <= bus.ex_wdata;
            r_mem_hi    <= bus.ex_hi;
            r_mem_lo    <= bus.ex_lo;
            r_mem_whilo <= bus.ex_whilo;
            r_mem_valid <= 1'b1;
            r_hilo      <= '0;
            r_cnt       <= '0;
        end else if (!w_mem_stall) begin
            r_mem_wd    <= '0;
            r_mem_wreg  <= 1'b0;
            r_mem_wdata <= '0;
            r_mem_hi    <= '0;
            r_mem_lo    <= '0;
            r_mem_whilo <= 1'b0;
            r_mem_valid <= 1'b0;
            r_hilo      <= bus.hilo_i;
            r_cnt       <= bus.cnt_i;
        end
    end

    assign bus.mem_wd    = r_mem_wd;
    assign bus.mem_wreg  = r_mem_wreg;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_hi    = r_mem_hi;
    assign bus.mem_lo    = r_mem_lo;
    assign bus.mem_whilo = r_mem_whilo;
    assign bus.mem_valid = r_mem_valid;
    assign bus.hilo_o    = r_hilo;
    assign bus.cnt_o     = r_cnt;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed vector bench for ex_mem_reg: table of stimulus/expected records
// plus hand-written async reset sequences.
module tb_ex_mem_reg;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 5;
    localparam int STALL_W = 6;
    localparam int OUT_W   = ADDR_W + 1 + 3*DATA_W + 1 + 1 + 2*DATA_W + 2;

    logic clk;
    logic rst;

    ex_mem_reg_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STALL_W(STALL_W)) bus ();

    ex_mem_reg #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STALL_W(STALL_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  stall;
        logic        flush;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        whilo;
        logic [63:0] hilo;
        logic [1:0]  cnt;
        logic [4:0]  e_wd;
        logic        e_wreg;
        logic [31:0] e_wdata;
        logic [31:0] e_hi;
        logic [31:0] e_lo;
        logic        e_whilo;
        logic        e_valid;
        logic [63:0] e_hilo;
        logic [1:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(
        input logic [5:0] st, input logic fl, input logic [4:0] wd, input logic wr,
        input logic [31:0] wdat, input logic [31:0] hi, input logic [31:0] lo,
        input logic wh, input logic [63:0] hl, input logic [1:0] cn,
        input logic [4:0] e_wd, input logic e_wr, input logic [31:0] e_wdat,
        input logic [31:0] e_hi, input logic [31:0] e_lo, input logic e_wh,
        input logic e_v, input logic [63:0] e_hl, input logic [1:0] e_cn);
        vec_t v;
        v.stall = st;  v.flush = fl;  v.wd = wd;  v.wreg = wr;  v.wdata = wdat;
        v.hi = hi;  v.lo = lo;  v.whilo = wh;  v.hilo = hl;  v.cnt = cn;
        v.e_wd = e_wd;  v.e_wreg = e_wr;  v.e_wdata = e_wdat;  v.e_hi = e_hi;
        v.e_lo = e_lo;  v.e_whilo = e_wh;  v.e_valid = e_v;  v.e_hilo = e_hl;
        v.e_cnt = e_cn;
        return v;
    endfunction

    function automatic logic [OUT_W-1:0] outs();
        return {bus.mem_wd, bus.mem_wreg, bus.mem_wdata, bus.mem_hi, bus.mem_lo,
                bus.mem_whilo, bus.mem_valid, bus.hilo_o, bus.cnt_o};
    endfunction

    function automatic logic [OUT_W-1:0] expv(input vec_t v);
        return {v.e_wd, v.e_wreg, v.e_wdata, v.e_hi, v.e_lo, v.e_whilo, v.e_valid,
                v.e_hilo, v.e_cnt};
    endfunction

    task automatic apply(input vec_t v);
        bus.stall    = v.stall;
        bus.flush    = v.flush;
        bus.ex_wd    = v.wd;
        bus.ex_wreg  = v.wreg;
        bus.ex_wdata = v.wdata;
        bus.ex_hi    = v.hi;
        bus.ex_lo    = v.lo;
        bus.ex_whilo = v.whilo;
        bus.hilo_i   = v.hilo;
        bus.cnt_i    = v.cnt;
    endtask

    task automatic check(input string name, input logic [OUT_W-1:0] act,
                         input logic [OUT_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // EX running while MEM stalls must never be requested by the stall controller
    always @(posedge clk) begin
        if (rst === 1'b1 && bus.stall[3] === 1'b0 && bus.stall[4] === 1'b1) begin
            errors++;
            $display("FAIL illegal_stall: got stall=%b required stall[4]=0 when stall[3]=0",
                     bus.stall);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t adv;
        vec_t cap;
        vec_t zero_v;

        // advance
        vecs.push_back(mk(6'b000000, 0, 5'd8, 1, 32'hDEADBEEF, 32'h1, 32'h2, 1, 64'hFFFF, 2'd2,
                          5'd8, 1, 32'hDEADBEEF, 32'h1, 32'h2, 1, 1, 64'h0, 2'd0));
        // madd cycle 1: bubble + capture
        vecs.push_back(mk(6'b001111, 0, 5'd9, 1, 32'h11111111, 32'h3, 32'h4, 1, 64'h0000_0001_0000_0002, 2'd1,
                          5'd0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 64'h0000_0001_0000_0002, 2'd1));
        // madd cycle 2: result advances, accumulation cleared
        vecs.push_back(mk(6'b000000, 0, 5'd9, 0, 32'h0, 32'h5, 32'h6, 1, 64'hABCD, 2'd2,
                          5'd9, 0, 32'h0, 32'h5, 32'h6, 1, 1, 64'h0, 2'd0));
        // capture with cnt=3 (no saturation), then hold three cycles
        vecs.push_back(mk(6'b001111, 0, 5'd10, 1, 32'h22222222, 32'h9, 32'h9, 1, 64'hCAFEBABE_12345678, 2'd3,
                          5'd0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 64'hCAFEBABE_12345678, 2'd3));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(6'b011111, 0, 5'(11 + i), 1, 32'h33330000 + i, 32'(i), 32'(i + 1), 1,
                              64'(i + 7), 2'(i),
                              5'd0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 64'hCAFEBABE_12345678, 2'd3));
        // advance, then hold three cycles with nonzero MEM contents
        vecs.push_back(mk(6'b000000, 0, 5'd17, 1, 32'h0A0B0C0D, 32'h7, 32'h8, 0, 64'h55, 2'd1,
                          5'd17, 1, 32'h0A0B0C0D, 32'h7, 32'h8, 0, 1, 64'h0, 2'd0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(6'b011111, 0, 5'(20 + i), 0, 32'h44440000 + i, 32'hF0, 32'hF1, 1,
                              64'(i + 99), 2'd3,
                              5'd17, 1, 32'h0A0B0C0D, 32'h7, 32'h8, 0, 1, 64'h0, 2'd0));
        // flush wins over EX stall
        vecs.push_back(mk(6'b001111, 1, 5'd30, 1, 32'h66666666, 32'h1, 32'h1, 1, 64'h1111, 2'd1,
                          5'd0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 64'h0, 2'd0));
        // back-to-back advance
        for (int i = 1; i <= 3; i++)
            vecs.push_back(mk(6'b000000, 0, 5'(i), 1, 32'h100 + i, 32'(i), 32'(i), 0, 64'h0, 2'd0,
                              5'(i), 1, 32'h100 + i, 32'(i), 32'(i), 0, 1, 64'h0, 2'd0));
        // flush with no stall kills valid data
        vecs.push_back(mk(6'b000000, 1, 5'd4, 1, 32'h77777777, 32'h2, 32'h3, 1, 64'h2222, 2'd2,
                          5'd0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 64'h0, 2'd0));

        zero_v = mk(6'b0, 0, 5'd0, 0, 32'h0, 32'h0, 32'h0, 0, 64'h0, 2'd0,
                    5'd0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 64'h0, 2'd0);
        adv = mk(6'b000000, 0, 5'd20, 1, 32'h55AA55AA, 32'h9, 32'hA, 1, 64'h3, 2'd1,
                 5'd20, 1, 32'h55AA55AA, 32'h9, 32'hA, 1, 1, 64'h0, 2'd0);
        cap = mk(6'b001111, 0, 5'd21, 1, 32'h1, 32'h1, 32'h1, 1, 64'h0123_4567_89AB_CDEF, 2'd1,
                 5'd0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 64'h0123_4567_89AB_CDEF, 2'd1);

        rst = 1'b0;
        apply(zero_v);
        #3;
        check("reset_state", outs(), '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            apply(vecs[i]);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), outs(), expv(vecs[i]));
        end

        // async reset mid-stream after nonzero data
        @(negedge clk);
        apply(adv);
        @(posedge clk);
        #1;
        check("pre_reset", outs(), expv(adv));
        #1;
        rst = 1'b0;
        #1;
        check("reset_async", outs(), '0);
        @(posedge clk);
        #1;
        check("reset_held", outs(), '0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("reset_release", outs(), '0);
        @(posedge clk);
        #1;
        check("post_reset_adv", outs(), expv(adv));

        // reset abandons a madd in progress
        @(negedge clk);
        apply(cap);
        @(posedge clk);
        #1;
        check("madd_capture", outs(), expv(cap));
        #1;
        rst = 1'b0;
        #1;
        check("madd_reset", outs(), '0);
        @(negedge clk);
        apply(zero_v);
        rst = 1'b1;
        @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_mem_reg.md
Name: ex_mem_reg

Overview:
- Pipeline register between the execute stage and the memory-access stage of the 5-stage MIPS core.
- Latches EX results (destination register, write enable, write data, HI/LO values, HI/LO write enable) for the memory-access stage.
- Honours the pipeline stall vector and flush: inserts bubbles, holds contents, or clears them.
- Carries the multi-cycle multiply-accumulate state (partial 64-bit product, cycle counter) back to EX across stall cycles for madd/msub.

Parameters:
- DATA_W, 32, general register / HI / LO width
- ADDR_W, 5, register-file address width
- STALL_W, 6, stall vector width: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous reset, active-low
- stall  in  STALL_W  per-stage stall request from the stall controller
- flush  in  1  pipeline flush; kills the instruction entering MEM
- ex_wd  in  ADDR_W  destination register from EX
- ex_wreg  in  1  register write enable from EX
- ex_wdata  in  DATA_W  register write data from EX
- ex_hi  in  DATA_W  HI value from EX
- ex_lo  in  DATA_W  LO value from EX
- ex_whilo  in  1  HI/LO write enable from EX
- hilo_i  in  2*DATA_W  partial product produced by EX on the first madd/msub cycle
- cnt_i  in  2  EX multi-cycle step counter
- mem_wd  out  ADDR_W  destination register to MEM
- mem_wreg  out  1  register write enable to MEM
- mem_wdata  out  DATA_W  register write data to MEM
- mem_hi  out  DATA_W  HI value to MEM
- mem_lo  out  DATA_W  LO value to MEM
- mem_whilo  out  1  HI/LO write enable to MEM
- mem_valid  out  1  MEM slot holds a real instruction, not a bubble
- hilo_o  out  2*DATA_W  partial product returned to EX
- cnt_o  out  2  step counter returned to EX

Behaviour:
- Reset:
  - Asynchronous: rst==0 immediately forces every output to 0.
  - This gives mem_wd=0 (NOP register), mem_wreg=0, mem_whilo=0, mem_valid=0, hilo_o=0, cnt_o=0.
  - Reset takes effect mid-operation, including during a madd/msub; the accumulation is abandoned.
- Clocked updates: all updates on rising clk while rst==1.
- Priority 1, flush==1:
  - Bubble: all mem_* outputs 0, mem_valid=0, hilo_o=0, cnt_o=0.
  - Applies regardless of stall.
- Priority 2, stall[3]==1 and stall[4]==0 (EX stalled, MEM free):
  - Insert bubble into MEM: mem_* outputs 0, mem_valid=0.
  - Capture accumulation state: hilo_o<=hilo_i, cnt_o<=cnt_i.
- Priority 3, stall[3]==0:
  - Normal advance: mem_*<=ex_* for all six fields; mem_valid<=1.
  - Clear accumulation state: hilo_o<=0, cnt_o<=0.
- Priority 4, stall[3]==1 and stall[4]==1:
  - Hold: every output keeps its value, including hilo_o and cnt_o.
- Latency:
  - 1 cycle from EX inputs to mem_* outputs.
  - 1 cycle from hilo_i/cnt_i to hilo_o/cnt_o.
- Combinational paths: none; every output is a flop.
- stall[3]==0 with stall[4]==1 is illegal from the stall controller. The block treats it as priority 3 (advance); the bench asserts it never occurs.
- The block performs no arithmetic; values pass through bit-exact.
- cnt_i is 2 bits. Value 2'b11 is passed through unchanged; no saturation.
- madd sequence timing:
  - Cycle N: EX asserts stall[3], drives cnt_i=1 and hilo_i=product.
  - Cycle N+1: EX reads cnt_o=1 and hilo_o, releases stall, completes.
  - Edge after N+1: cnt_o returns to 0.

Test Plan:
- Reset with rst=0 mid-stream, after nonzero data has been latched -> all outputs 0 immediately without waiting for a clock edge; they remain 0 until the first edge after rst=1.
- Normal advance, stall=0, with ex_wd=5'd8, ex_wreg=1, ex_wdata=32'hDEADBEEF, ex_whilo=1, ex_hi=32'h1, ex_lo=32'h2:
  - After next edge: mem_wd=8, mem_wreg=1, mem_wdata=DEADBEEF, mem_hi=1, mem_lo=2, mem_whilo=1, mem_valid=1, cnt_o=0.
- madd two-cycle flow:
  - Cycle 1: stall=6'b001111, cnt_i=1, hilo_i=64'h0000_0001_0000_0002 -> next edge: mem_valid=0, mem_wreg=0, cnt_o=1, hilo_o=64'h0000_0001_0000_0002.
  - Cycle 2: stall=0 -> next edge: mem_* carry EX result, cnt_o=0, hilo_o=0.
- Hold with stall=6'b011111 for 3 cycles, ex_* changing every cycle -> all outputs unchanged from the pre-stall values, including cnt_o.
- Flush with stall=6'b001111 and flush=1 simultaneously -> next edge: all outputs 0, cnt_o=0 (flush wins over stall).
- Back-to-back advance, three consecutive instructions with distinct ex_wd (1, 2, 3) and stall=0 -> mem_wd sequence 1, 2, 3 on consecutive edges, mem_valid held at 1.
